// File: rtl/lsb_pkg.sv
// Shared definitions for the LED/switch/button poller: FSM encoding and the
// layout of the device status word.
package lsb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_e;

   localparam int BTN_LSB = 8;
   localparam int SWI_LSB = 0;
   localparam int FIELD_W = 4;

   // Packs the device status word into {btn, swi}.
   function automatic logic [7:0] status_of(input logic [31:0] din);
      return {din[BTN_LSB +: FIELD_W], din[SWI_LSB +: FIELD_W]};
   endfunction

endpackage

// File: rtl/lsb_poller_poll_timer.sv
// Free-running PERIOD down-counter; tick is high in the cycle the count sits at
// zero with enable set. Disabling parks the count at PERIOD-1.
module poll_timer #(
   parameter int PERIOD = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int CW = $clog2(PERIOD);
   localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = 1'b0;
      cnt_d = cnt_q;
      if (!enable) begin
         cnt_d = RELOAD;
      end else if (cnt_q == '0) begin
         tick  = 1'b1;
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= RELOAD;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/lsb_poller.sv
// Bus initiator for the LED/switch/button device: periodic status polling with
// change events, forwarded LED writes, and a per-transaction ack timeout.
// Bus handshake: a transaction holds bus_stb high until bus_ack is sampled high
// at a clock edge (or the timeout expires); bus_we/bus_dout are stable meanwhile.
module lsb_poller
   import lsb_pkg::*;
#(
   parameter int PERIOD  = 50000,
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [7:0]  led_val,
   input  logic        led_wr,
   output logic        bus_stb,
   output logic        bus_we,
   output logic [7:0]  bus_dout,
   input  logic [31:0] bus_din,
   input  logic        bus_ack,
   output logic [7:0]  sample,
   output logic        valid,
   output logic        evt,
   output logic [7:0]  chg_mask,
   output logic        err,
   input  logic        err_clr
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);

   state_e        state_q, state_d;
   logic          stb_q, stb_d;
   logic          we_q, we_d;
   logic [7:0]    dout_q, dout_d;
   logic [7:0]    sample_q, sample_d;
   logic          valid_q, valid_d;
   logic          evt_q, evt_d;
   logic [7:0]    chg_q, chg_d;
   logic          err_q, err_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          wr_pend_q, wr_pend_d;
   logic [7:0]    wr_val_q, wr_val_d;
   logic          poll_pend_q, poll_pend_d;

   logic          tick;
   logic [7:0]    new_sample;
   logic [TW-1:0] tmo_inc;
   logic          unused_din;

   assign unused_din = ^{bus_din[31:12], bus_din[7:4]};

   poll_timer #(.PERIOD(PERIOD)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .tick   (tick)
   );

   always_comb begin
      state_d     = state_q;
      stb_d       = stb_q;
      we_d        = we_q;
      dout_d      = dout_q;
      sample_d    = sample_q;
      valid_d     = valid_q;
      evt_d       = 1'b0;
      chg_d       = chg_q;
      err_d       = err_q;
      tmo_d       = tmo_q;
      wr_pend_d   = wr_pend_q;
      wr_val_d    = wr_val_q;
      poll_pend_d = poll_pend_q;
      new_sample  = status_of(bus_din);
      tmo_inc     = tmo_q + 1'b1;

      if (err_clr) err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (wr_pend_q) begin
               state_d = WRITE;
               stb_d   = 1'b1;
               we_d    = 1'b1;
               dout_d  = wr_val_q;
               tmo_d   = '0;
            end else if (poll_pend_q) begin
               state_d = READ;
               stb_d   = 1'b1;
               we_d    = 1'b0;
               tmo_d   = '0;
            end
         end
         WRITE, READ: begin
            if (bus_ack) begin
               stb_d   = 1'b0;
               we_d    = 1'b0;
               state_d = IDLE;
               if (state_q == WRITE) begin
                  wr_pend_d = 1'b0;
               end else begin
                  sample_d    = new_sample;
                  valid_d     = 1'b1;
                  poll_pend_d = 1'b0;
                  if (valid_q && (new_sample != sample_q)) begin
                     evt_d = 1'b1;
                     chg_d = new_sample ^ sample_q;
                  end
               end
            end else if (tmo_inc == TMO_LIM) begin
               // Pending flag is left set so the same transaction is retried.
               stb_d   = 1'b0;
               we_d    = 1'b0;
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_inc;
            end
         end
         default: state_d = IDLE;
      endcase

      // New requests land after completion so a same-cycle request survives.
      if (tick)   poll_pend_d = 1'b1;
      if (led_wr) begin
         wr_pend_d = 1'b1;
         wr_val_d  = led_val;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         dout_q      <= '0;
         sample_q    <= '0;
         valid_q     <= 1'b0;
         evt_q       <= 1'b0;
         chg_q       <= '0;
         err_q       <= 1'b0;
         tmo_q       <= '0;
         wr_pend_q   <= 1'b0;
         wr_val_q    <= '0;
         poll_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         dout_q      <= dout_d;
         sample_q    <= sample_d;
         valid_q     <= valid_d;
         evt_q       <= evt_d;
         chg_q       <= chg_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
         wr_pend_q   <= wr_pend_d;
         wr_val_q    <= wr_val_d;
         poll_pend_q <= poll_pend_d;
      end
   end

   assign bus_stb  = stb_q;
   assign bus_we   = we_q;
   assign bus_dout = dout_q;
   assign sample   = sample_q;
   assign valid    = valid_q;
   assign evt      = evt_q;
   assign chg_mask = chg_q;
   assign err      = err_q;

endmodule

// File: tb/tb_lsb_poller.sv
// Bench for lsb_poller: directed scenarios plus random traffic against a
// transaction-level reference model, with a device model that acks on stb.
module tb_lsb_poller;

   localparam int P = 8;
   localparam int T = 3;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic        enable, led_wr, err_clr, ack_en;
   logic [7:0]  led_val;
   logic [31:0] din_v;
   logic        bus_stb, bus_we, bus_ack, valid, evt, err;
   logic [7:0]  bus_dout, sample, chg_mask;
   logic [7:0]  led_reg;

   assign bus_ack = bus_stb & ack_en;

   lsb_poller #(.PERIOD(P), .TIMEOUT(T)) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .led_val  (led_val),
      .led_wr   (led_wr),
      .bus_stb  (bus_stb),
      .bus_we   (bus_we),
      .bus_dout (bus_dout),
      .bus_din  (din_v),
      .bus_ack  (bus_ack),
      .sample   (sample),
      .valid    (valid),
      .evt      (evt),
      .chg_mask (chg_mask),
      .err      (err),
      .err_clr  (err_clr)
   );

   // Device LED register.
   initial led_reg = 8'h00;
   always @(posedge clk) if (bus_stb && bus_we && bus_ack) led_reg <= bus_dout;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   int n_chk = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // Transaction view: busy = 0 none, 1 write in flight, 2 read in flight;
   // age counts unacked cycles of the current transaction.
   int         m_cnt, m_busy, m_age;
   bit         m_poll, m_wr, m_valid, m_evt, m_err, model_live;
   logic [7:0] m_wrval, m_dout, m_sample, m_chg;
   initial model_live = 1'b0;

   always @(posedge clk) begin : model
      bit ack, tick;
      logic [7:0] nw;
      if (!rst) begin
         m_cnt = P - 1; m_poll = 0; m_wr = 0; m_wrval = 0; m_busy = 0; m_age = 0;
         m_dout = 0; m_sample = 0; m_valid = 0; m_evt = 0; m_chg = 0; m_err = 0;
         exp_q.delete();
         model_live = 1'b1;
      end else begin
         ack  = (m_busy != 0) && ack_en;
         tick = enable && (m_cnt == 0);
         m_cnt = !enable ? P - 1 : (m_cnt == 0 ? P - 1 : m_cnt - 1);
         m_evt = 0;
         if (err_clr) m_err = 0;
         if (m_busy != 0) begin
            if (ack) begin
               if (m_busy == 1) m_wr = 0;
               else begin
                  nw = {din_v[11:8], din_v[3:0]};
                  if (m_valid && nw != m_sample) begin
                     m_evt = 1;
                     m_chg = nw ^ m_sample;
                     exp_q.push_back(nw);
                  end
                  m_sample = nw;
                  m_valid  = 1;
                  m_poll   = 0;
               end
               m_busy = 0;
            end else begin
               m_age++;
               if (m_age == T) begin
                  m_busy = 0;
                  m_err  = 1;
               end
            end
         end else if (m_wr) begin
            m_busy = 1; m_dout = m_wrval; m_age = 0;
         end else if (m_poll) begin
            m_busy = 2; m_age = 0;
         end
         if (tick) m_poll = 1;
         if (led_wr) begin
            m_wr = 1; m_wrval = led_val;
         end
      end
   end

   // Per-cycle compare against the model, plus evt ordering via exp_q.
   always @(negedge clk) begin
      if (model_live) begin
         chk("stb",      bus_stb,  m_busy != 0);
         chk("we",       bus_we,   m_busy == 1);
         chk("dout",     bus_dout, m_dout);
         chk("sample",   sample,   m_sample);
         chk("valid",    valid,    m_valid);
         chk("evt",      evt,      m_evt);
         chk("chg_mask", chg_mask, m_chg);
         chk("err",      err,      m_err);
         if (evt === 1'b1) begin
            if (exp_q.size() == 0) chk("evt_expected", 1, 0);
            else chk("evt_sample", sample, exp_q.pop_front());
         end
      end
   end

   // ---------------- bus monitor ----------------
   int   rise_cyc[$];
   logic rise_we[$];
   int   wid_q[$];
   int   stb_w = 0;
   logic stb_prev = 1'b0;
   int   n_evt_seen = 0;

   always @(negedge clk) begin
      if (bus_stb === 1'b1 && !stb_prev) begin
         rise_cyc.push_back(cyc);
         rise_we.push_back(bus_we);
      end
      if (bus_stb === 1'b1) stb_w++;
      else if (stb_prev) begin
         wid_q.push_back(stb_w);
         stb_w = 0;
      end
      stb_prev = (bus_stb === 1'b1);
      if (evt === 1'b1) n_evt_seen++;
   end

   // ---------------- driver tasks ----------------
   task automatic clear_logs();
      @(posedge clk);
      #1;
      rise_cyc.delete(); rise_we.delete(); wid_q.delete(); n_evt_seen = 0;
   endtask

   // sel: 0 stb rise, 1 evt, 2 valid, 3 stb with we
   task automatic wait_for(input int sel, input int lim, output bit ok);
      bit prev;
      ok   = 1'b0;
      prev = (bus_stb === 1'b1);
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         case (sel)
            0: ok = (bus_stb === 1'b1) && !prev;
            1: ok = (evt === 1'b1);
            2: ok = (valid === 1'b1);
            default: ok = (bus_stb === 1'b1) && (bus_we === 1'b1);
         endcase
         prev = (bus_stb === 1'b1);
         if (ok) break;
      end
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin : main
      bit ok;
      int n0;
      bit stall;
      rst = 1'b0; enable = 1'b0; led_val = 8'h00; led_wr = 1'b0;
      err_clr = 1'b0; ack_en = 1'b1; din_v = 32'h0000_0305;
      repeat (3) @(negedge clk);
      chk("rst_stb", bus_stb, 0);
      chk("rst_we", bus_we, 0);
      chk("rst_dout", bus_dout, 0);
      chk("rst_sample", sample, 0);
      chk("rst_valid", valid, 0);
      chk("rst_err", err, 0);
      rst = 1'b1; enable = 1'b1;

      // Periodic polling with a fixed status word.
      clear_logs();
      repeat (40) @(negedge clk);
      chk("poll_sample", sample, 8'h35);
      chk("poll_valid", valid, 1);
      chk("poll_no_evt", n_evt_seen, 0);
      chk("poll_count_ge4", rise_cyc.size() >= 4, 1);
      foreach (rise_we[i]) chk("poll_is_read", rise_we[i], 0);
      foreach (wid_q[i]) chk("poll_stb_width", wid_q[i], 1);
      for (int i = 1; i < rise_cyc.size(); i++) chk("poll_interval", rise_cyc[i] - rise_cyc[i-1], P);

      // Status change raises a single-cycle event.
      @(negedge clk);
      din_v = 32'h0000_0105;
      wait_for(1, 20, ok);
      chk("chg_evt_seen", ok, 1);
      chk("chg_mask_val", chg_mask, 8'h20);
      chk("chg_sample", sample, 8'h15);
      @(negedge clk);
      chk("chg_evt_one_cycle", evt, 0);
      chk("chg_mask_hold", chg_mask, 8'h20);

      // LED write forwarded to the device.
      led_val = 8'hA5; led_wr = 1'b1;
      @(negedge clk);
      led_wr = 1'b0;
      wait_for(3, 20, ok);
      chk("wr_seen", ok, 1);
      chk("wr_dout", bus_dout, 8'hA5);
      repeat (2) @(negedge clk);
      chk("wr_led_reg", led_reg, 8'hA5);

      // Write and poll pending together: write goes first.
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_cnt == 0 && m_busy == 0 && !m_poll && !m_wr) begin
            ok = 1'b1;
            break;
         end
      end
      chk("prio_setup", ok, 1);
      n0 = rise_cyc.size();
      led_val = 8'h3C; led_wr = 1'b1;
      @(negedge clk);
      led_wr = 1'b0;
      repeat (6) @(negedge clk);
      chk("prio_two_txn", rise_cyc.size() >= n0 + 2, 1);
      if (rise_cyc.size() >= n0 + 2) begin
         chk("prio_first_write", rise_we[n0], 1);
         chk("prio_then_read", rise_we[n0+1], 0);
         chk("prio_back_to_back", rise_cyc[n0+1] - rise_cyc[n0], 2);
      end
      chk("prio_led_reg", led_reg, 8'h3C);

      // Timeout, retry, err_clr, recovery.
      ack_en = 1'b0;
      wait_for(0, 20, ok);
      chk("tmo_stb_seen", ok, 1);
      n0 = wid_q.size();
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (wid_q.size() > n0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("tmo_dropped", ok, 1);
      if (ok) chk("tmo_stb_width", wid_q[n0], T);
      chk("tmo_err", err, 1);
      wait_for(0, 5, ok);
      chk("tmo_retry", ok, 1);
      chk("tmo_retry_is_read", bus_we, 0);
      ack_en = 1'b1; err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("tmo_err_cleared", err, 0);
      chk("tmo_retry_done", bus_stb, 0);

      // Reset in the middle of a transaction.
      ack_en = 1'b0;
      wait_for(0, 20, ok);
      chk("rst_mid_stb_seen", ok, 1);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_stb", bus_stb, 0);
      chk("rst_mid_we", bus_we, 0);
      chk("rst_mid_dout", bus_dout, 0);
      chk("rst_mid_sample", sample, 0);
      chk("rst_mid_valid", valid, 0);
      chk("rst_mid_chg", chg_mask, 0);
      rst = 1'b1; ack_en = 1'b1; din_v = 32'h0000_0A0B;
      clear_logs();
      wait_for(2, 30, ok);
      chk("rst_first_valid", ok, 1);
      chk("rst_first_sample", sample, 8'hAB);
      repeat (20) @(negedge clk);
      chk("rst_first_no_evt", n_evt_seen, 0);

      // Random traffic against the model.
      stall = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (i % 200 == 0) stall = ($urandom_range(0, 1) == 1);
         rst     = ($urandom_range(0, 299) != 0);
         enable  = ($urandom_range(0, 9) != 0);
         led_wr  = ($urandom_range(0, 15) == 0);
         led_val = 8'($urandom_range(0, 255));
         ack_en  = ($urandom_range(0, stall ? 1 : 5) != 0);
         err_clr = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 9) == 0) din_v = $urandom;
      end
      @(negedge clk);
      rst = 1'b1; led_wr = 1'b0; err_clr = 1'b0; ack_en = 1'b1;
      repeat (20) @(negedge clk);
      chk("exp_q_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/lsb_poller.md
Name: lsb_poller

Overview:
- Bus initiator for the LED/switch/button I/O device. It drives that device's stb/we/data_in/ack interface from the master side.
- It polls the switch/button status register periodically and reports changes as one-cycle events with a change mask.
- It forwards LED values requested by local logic as bus writes.
- It sits between local control logic and the I/O device, so status can be monitored and LEDs driven without CPU involvement.

Parameters:
- PERIOD, 50000, clock cycles between poll reads (>= 2)
- TIMEOUT, 15, cycles stb may stay high without ack before the transaction is aborted (>= 1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- enable  in  1  1 = periodic polling runs; 0 = poll counter held at PERIOD-1, pending writes still served
- led_val  in  8  LED value to write
- led_wr  in  1  one-cycle request to write led_val
- bus_stb  out  1  strobe to device
- bus_we  out  1  1 = write, 0 = read
- bus_dout  out  8  write data to device
- bus_din  in  32  read data from device: btn at [11:8], swi at [3:0]
- bus_ack  in  1  device acknowledge
- sample  out  8  last read status {btn[3:0], swi[3:0]}
- valid  out  1  1 after the first successful read
- evt  out  1  one-cycle pulse when sample changed
- chg_mask  out  8  sample_new XOR sample_old, valid while evt=1
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err

Behaviour:
- Reset (rst=0 at a clk edge) sets:
  - bus_stb, bus_we, bus_dout = 0
  - sample, chg_mask = 0
  - valid, evt, err = 0
  - state = IDLE, poll counter = PERIOD-1, pending flags cleared
  - If reset arrives mid-transaction, it drops stb in the same edge and the transaction is lost.
- All outputs are registered.
- Poll counter:
  - Decrements each cycle while enable=1.
  - At 0 it sets poll_pend and reloads PERIOD-1.
  - A poll_pend that is already set absorbs further expiries; polls never queue.
- Write request:
  - led_wr=1 latches led_val into wr_val and sets wr_pend.
  - A later led_wr before service overwrites wr_val: the latest value wins.
- States: IDLE, WRITE, READ.
  - IDLE: if wr_pend -> WRITE; else if poll_pend -> READ. Writes have priority.
  - On entry to WRITE: bus_stb=1, bus_we=1, bus_dout=wr_val, timeout counter=0.
  - On entry to READ: bus_stb=1, bus_we=0, timeout counter=0.
  - While in WRITE/READ, the block samples bus_ack each cycle with stb high. On ack=1: bus_stb=0, bus_we=0, next state IDLE.
  - With a device that acks combinationally, stb is high for exactly 1 cycle and a transaction takes 2 cycles IDLE->IDLE.
- WRITE ack:
  - Clears wr_pend.
  - If led_wr=1 in the same cycle, wr_val and wr_pend take the new request and the write is repeated.
- READ ack:
  - Captures new = {bus_din[11:8], bus_din[3:0]} into sample and clears poll_pend.
  - If valid=1 and new != sample: evt=1 for one cycle and chg_mask = new ^ sample.
  - The first read after reset sets valid=1 and never raises evt.
  - chg_mask holds its value until the next evt.
- Timeout:
  - The timeout counter increments each cycle in WRITE/READ without ack.
  - When it reaches TIMEOUT: drop stb, set err, return to IDLE.
  - The pending flag stays set, so the transaction is retried.
  - err_clr=1 clears err. If a timeout and err_clr occur in the same cycle, the timeout wins (err=1).
- bus_dout keeps the last written value after the write completes. It has no meaning during reads.

Decomposition:
- Shared package lsb_pkg:
  - state encoding (IDLE=0, WRITE=1, READ=2)
  - status field offsets BTN_LSB=8, SWI_LSB=0
  - field width 4
- Sub-module poll_timer: PERIOD down-counter with enable, producing a one-cycle tick.
- The FSM, the capture/compare logic and the timeout counter live in lsb_poller.

Test Plan:
- Reset, then PERIOD=8 with a combinational-ack device model (ack=stb) returning din=0x00000305 -> read stb pulse of 1 cycle with we=0 every 8 cycles; sample=0x35, valid=1, evt stays 0.
- Change the model to din=0x00000105 -> at the next poll completion evt=1 for exactly 1 cycle, chg_mask=0x20, sample=0x15.
- led_wr with led_val=0xA5 -> next transaction has stb=1, we=1, bus_dout=0xA5; the device model LED register reads 0xA5.
- Write and poll pending simultaneously -> WRITE is issued first, READ in the immediately following transaction.
- Model never acks, TIMEOUT=3 -> stb high for 3 cycles then dropped, err=1, retry follows. err_clr pulse -> err=0; ack restored -> the retry completes.
- Assert rst=0 while stb=1 -> all outputs 0 on the next edge. After release, the first read sets valid with no evt.
